// File: rtl/bus_arbiter_rr_if.sv
// Memory-bus bundle around the NCH-to-1 arbiter: per-channel ibus/dbus
// style requests with their completion pulses on one side, and a single
// downstream request/ack port on the other.
interface bus_arbiter_rr_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
);
    // Requester side: channel i occupies slice [i*W +: W] of each vector.
    logic [NCH-1:0]        req_valid;
    logic [NCH*ADDR_W-1:0] req_addr;
    logic [NCH*3-1:0]      req_size;
    logic [NCH*STRB_W-1:0] req_strobe;
    logic [NCH*DATA_W-1:0] req_data;
    logic [NCH-1:0]        resp_data_ok;
    logic [DATA_W-1:0]     resp_data;

    // Downstream side: one transaction at a time.
    logic                  m_valid;
    logic [ADDR_W-1:0]     m_addr;
    logic [2:0]            m_size;
    logic [STRB_W-1:0]     m_strobe;
    logic [DATA_W-1:0]     m_data;
    logic                  m_data_ok;
    logic [DATA_W-1:0]     m_rdata;

    // Arbiter view: serves the requesters, drives the downstream bus.
    modport slave (
        input  req_valid, req_addr, req_size, req_strobe, req_data,
        output resp_data_ok, resp_data,
        output m_valid, m_addr, m_size, m_strobe, m_data,
        input  m_data_ok, m_rdata
    );

    // Surrounding system view: requesters plus the downstream memory.
    modport master (
        output req_valid, req_addr, req_size, req_strobe, req_data,
        input  resp_data_ok, resp_data,
        input  m_valid, m_addr, m_size, m_strobe, m_data,
        output m_data_ok, m_rdata
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// NCH-channel memory-bus arbiter. Picks one valid requester (round-robin or
// fixed priority), latches its request and presents it downstream until
// m_data_ok. A requester that withdraws while its transaction is in flight
// gets no completion pulse; the downstream transaction still finishes.
module bus_arbiter_rr #(
    parameter int NCH        = 2,
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STRB_W     = DATA_W / 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic               clk,
    input  logic               reset,   // asynchronous, active low
    bus_arbiter_rr_if.slave    bus,
    output logic               busy
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                dropped_q, dropped_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [STRB_W-1:0]   strobe_q, strobe_d;
    logic [DATA_W-1:0]   data_q, data_d;

    // Per-channel views of the flattened request vectors.
    logic [ADDR_W-1:0]   ch_addr   [NCH];
    logic [2:0]          ch_size   [NCH];
    logic [STRB_W-1:0]   ch_strobe [NCH];
    logic [DATA_W-1:0]   ch_data   [NCH];

    logic [GW-1:0]       scan_base;
    logic [GW-1:0]       winner;
    logic                winner_found;
    logic [GW-1:0]       cand;
    int                  idx;
    logic [GW-1:0]       next_ptr;
    logic                in_flight;
    logic                grant_valid;
    logic                ack_ok;

    assign in_flight   = (state_q == BUSY);
    assign busy        = in_flight;
    assign grant_valid = bus.req_valid[grant_q];

    // Completion is forwarded only if the owner never withdrew and still wants it.
    assign ack_ok = in_flight & bus.m_data_ok & ~dropped_q & grant_valid;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        assign ch_addr[gi]   = bus.req_addr[gi*ADDR_W +: ADDR_W];
        assign ch_size[gi]   = bus.req_size[gi*3 +: 3];
        assign ch_strobe[gi] = bus.req_strobe[gi*STRB_W +: STRB_W];
        assign ch_data[gi]   = bus.req_data[gi*DATA_W +: DATA_W];
        assign bus.resp_data_ok[gi] = ack_ok && (grant_q == GW'(gi));
    end

    // Read data is passed straight through in the ack cycle and zero otherwise.
    assign bus.resp_data = ack_ok ? bus.m_rdata : '0;

    // Downstream fields come only from the latched copy, zero when idle.
    assign bus.m_valid  = in_flight;
    assign bus.m_addr   = in_flight ? addr_q   : '0;
    assign bus.m_size   = in_flight ? size_q   : '0;
    assign bus.m_strobe = in_flight ? strobe_q : '0;
    assign bus.m_data   = in_flight ? data_q   : '0;

    // Fixed priority always scans from channel 0; round-robin from the pointer.
    assign scan_base = (FIXED_PRIO != 0) ? '0 : rr_ptr_q;

    // Pointer moves to the channel after the one just served.
    assign next_ptr = (int'(grant_q) >= NCH - 1) ? '0 : grant_q + 1'b1;

    // Winner select: scan backwards so the first valid channel in scan order is kept.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        idx          = 0;
        cand         = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = int'(scan_base) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            cand = idx[GW-1:0];
            if (bus.req_valid[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end

    // Next-state logic: grant from IDLE, track withdrawal and completion in BUSY.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        dropped_d = dropped_q;
        addr_d    = addr_q;
        size_d    = size_q;
        strobe_d  = strobe_q;
        data_d    = data_q;
        case (state_q)
            IDLE: begin
                if (winner_found) begin
                    state_d   = BUSY;
                    grant_d   = winner;
                    dropped_d = 1'b0;
                    addr_d    = ch_addr[winner];
                    size_d    = ch_size[winner];
                    strobe_d  = ch_strobe[winner];
                    data_d    = ch_data[winner];
                end
            end
            BUSY: begin
                // Once the owner lets go, its response is lost even if it re-requests.
                if (!grant_valid) begin
                    dropped_d = 1'b1;
                end
                if (bus.m_data_ok) begin
                    state_d = IDLE;
                    if (FIXED_PRIO == 0) begin
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-request registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            dropped_q <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            strobe_q  <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            dropped_q <= dropped_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            strobe_q  <= strobe_d;
            data_q    <= data_d;
        end
    end

    // A downstream completion with nothing in flight is a protocol violation.
    a_no_ack_when_idle : assert property (
        @(posedge clk) disable iff (!reset) !((state_q == IDLE) && bus.m_data_ok)
    );

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised N-channel memory-bus arbiter that replaces the fixed ibus/dbus glue at core top.
- Merges NCH requesters (fetch, load/store, future PTW/cache-refill) onto one downstream bus using the ibus/dbus valid-hold/data_ok protocol.
- Registers the granted request, so downstream sees stable fields for the whole transaction.
- Provides round-robin or fixed-priority selection, and drops the response of any requester that withdraws while its transaction is in flight (for example, pipeline flush).

Parameters:
NCH, 2, number of requesting channels (1..8); channel 0 = ibus.
ADDR_W, 64, address width.
DATA_W, 64, data width.
STRB_W, DATA_W/8, byte-strobe width.
FIXED_PRIO, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
req_valid  in  NCH  per-channel request valid, held until resp_data_ok or withdrawn
req_addr  in  NCH*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W]
req_size  in  NCH*3  per-channel size code (msize encoding)
req_strobe  in  NCH*STRB_W  per-channel write strobe; 0 = read
req_data  in  NCH*DATA_W  per-channel write data
resp_data_ok  out  NCH  one-cycle completion pulse to the granted channel
resp_data  out  DATA_W  read data, shared by all channels, valid with resp_data_ok
m_valid  out  1  downstream request valid
m_addr  out  ADDR_W  downstream address
m_size  out  3  downstream size
m_strobe  out  STRB_W  downstream strobe
m_data  out  DATA_W  downstream write data
m_data_ok  in  1  downstream completion
m_rdata  in  DATA_W  downstream read data
busy  out  1  transaction in flight (status / debug)

Behaviour:
- Reset and idle state:
  - Async assert (reset=0) forces state=IDLE, grant=0, rr_ptr=0, dropped=0.
  - All m_* fields = 0, m_valid=0, busy=0, resp_data_ok=0. These values persist until the first clk edge after reset=1.
  - Reset mid-transaction abandons it silently; no resp_data_ok is issued.
- FSM states: IDLE and BUSY.
- IDLE:
  - If any req_valid: select a winner.
    - FIXED_PRIO=1: lowest set index wins.
    - FIXED_PRIO=0: first set index scanning rr_ptr, rr_ptr+1, ... mod NCH.
  - On that edge, latch winner index, addr, size, strobe and data into registers; dropped<=0; go BUSY.
  - No req_valid: stay in IDLE.
- BUSY:
  - m_valid=1 and busy=1; m_* come from the latched registers only. Requester changes to its fields are ignored.
  - dropped<=1 on any cycle where req_valid[grant]=0. It is sticky until the next grant.
  - On m_data_ok=1 in the same cycle:
    - resp_data_ok[grant] = ~dropped & req_valid[grant]; all other bits are 0.
    - resp_data = m_rdata; this is combinational passthrough, zero added latency.
  - At that edge: state<=IDLE; rr_ptr<=(grant+1) mod NCH, in round-robin mode only.
- Latency and throughput:
  - Minimum request-to-m_valid latency is 1 cycle.
  - Minimum request-to-resp_data_ok latency is 1 cycle plus downstream latency.
  - The mandatory IDLE cycle between transactions gives a maximum of 1 transaction per 2 cycles.
- resp_data when no pulse: held 0 whenever resp_data_ok is all-zero, for difftest cleanliness.
- Writes vs reads: the arbiter does not distinguish them. A write still waits for m_data_ok. A dropped write still completes downstream; abort happens before the grant only.
- NCH=1: degenerates to a register slice; rr_ptr stays 0.
- Fairness: in round-robin mode with all channels continuously valid, grants cycle 0,1,..,NCH-1,0. No channel waits more than NCH transactions.
- m_data_ok while IDLE: illegal; it is ignored (no pulse), and an assertion fires in simulation.

Test Plan:
1. Single read, ch0: NCH=2; req_valid=01, addr=0x80000000, strobe=0; downstream acks 2 cycles after m_valid with m_rdata=0x13 -> m_valid rises 1 cycle after request; resp_data_ok=01 and resp_data=0x13 in the ack cycle; busy falls the next cycle.
2. Round-robin contention: req_valid=11 held continuously; downstream acks every cycle m_valid=1 -> grant order 0,1,0,1; ch1 request is not started until ch0's ack; no resp_data_ok bit is ever set for a channel other than grant.
3. Fixed priority: FIXED_PRIO=1, NCH=3, req_valid=111 continuously -> ch0 granted every transaction; ch1 granted only after ch0 deasserts.
4. Withdraw mid-flight: ch1 store granted (strobe=0xFF, data=0xDEADBEEF); ch1 drops valid 1 cycle later; ack 3 cycles later -> m_data stays 0xDEADBEEF throughout; resp_data_ok stays 00; state returns to IDLE; rr_ptr=0.
5. Async reset in BUSY: reset=0 mid-transaction -> m_valid=0 and busy=0 immediately, without a clk edge; after release with req_valid=10 -> ch1 granted; rr_ptr starts from 0.
6. Field stability: requester changes req_addr from 0x1000 to 0x2000 while BUSY -> m_addr stays 0x1000 until ack.
